instruction_fetch_ras: RTL and testbench

Parametrised next-generation instruction fetch unit for the EXE stage.
- Dual-port prefetch: fall-through on IMEM port 1, branch target on IMEM port 2. A taken branch issues its instruction with no fetch bubble.
- Adds CALL/RETURN subroutine support through an internal return-address stack (RAS) of configurable depth.
- Sits between IMEM (two synchronous read ports, 1-cycle latency) and the EXE decode/execute logic.

---
 rtl/instruction_fetch_ras_pkg.sv | 20 ++
 rtl/instruction_fetch_ras_return_address_stack.sv | 54 +++++
 rtl/instruction_fetch_ras.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch_ras.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_ras_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, fetch state encoding and default widths.
package instruction_fetch_ras_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 16;
  localparam int DEFAULT_INSTR_WIDTH = 64;
  localparam int DEFAULT_OP_LENGTH   = 8;
  localparam int DEFAULT_TARGET_LSB  = 32;
  localparam int DEFAULT_RAS_DEPTH   = 4;

  localparam logic [7:0] DEFAULT_OPCODE_RETURN = 8'h02;
  localparam logic [7:0] DEFAULT_OPCODE_CALL   = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_EXEC  = 2'd3
  } fetchState_t;

endpackage

// File: rtl/instruction_fetch_ras_return_address_stack.sv
// Return-address stack: LIFO of call-site+1 addresses with occupancy count.
module return_address_stack
  import instruction_fetch_ras_pkg::*;
#(
  parameter int RAS_DEPTH  = DEFAULT_RAS_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  localparam int DEPTH_WIDTH = $clog2(RAS_DEPTH + 1),
  localparam int IDX_WIDTH   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [ADDR_WIDTH-1:0]  pushAddr,
  output logic [ADDR_WIDTH-1:0]  topAddr,
  output logic                   full,
  output logic                   empty,
  output logic [DEPTH_WIDTH-1:0] depth
);

  logic [ADDR_WIDTH-1:0]  stackMem [RAS_DEPTH];
  logic [DEPTH_WIDTH-1:0] depthReg;
  logic [IDX_WIDTH-1:0]   writeIdx;
  logic [IDX_WIDTH-1:0]   topIdx;

  assign writeIdx = IDX_WIDTH'(depthReg);
  assign topIdx   = IDX_WIDTH'(depthReg - 1'b1);
  assign full     = (depthReg == DEPTH_WIDTH'(RAS_DEPTH));
  assign empty    = (depthReg == '0);
  assign depth    = depthReg;
  assign topAddr  = stackMem[topIdx];

  always_ff @(posedge Clock) begin
    if (push && !full) begin
      stackMem[writeIdx] <= pushAddr;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      depthReg <= '0;
    end else if (clear) begin
      depthReg <= '0;
    end else if (push && !full) begin
      depthReg <= depthReg + 1'b1;
    end else if (pop && !empty) begin
      depthReg <= depthReg - 1'b1;
    end
  end

  pushPopExclusive: assert property (@(posedge Clock) disable iff (!Reset) !(push && pop));

endmodule

// File: rtl/instruction_fetch_ras.sv
// Dual-port prefetching instruction fetch unit with CALL/RETURN support via a return-address stack.
module instruction_fetch_ras
  import instruction_fetch_ras_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int OP_LENGTH   = DEFAULT_OP_LENGTH,
  parameter int TARGET_LSB  = DEFAULT_TARGET_LSB,
  parameter int RAS_DEPTH   = DEFAULT_RAS_DEPTH,
  parameter logic [OP_LENGTH-1:0] OPCODE_RETURN = OP_LENGTH'(DEFAULT_OPCODE_RETURN),
  parameter logic [OP_LENGTH-1:0] OPCODE_CALL   = OP_LENGTH'(DEFAULT_OPCODE_CALL),
  localparam int DEPTH_WIDTH = $clog2(RAS_DEPTH + 1)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iTrigger,
  input  logic [ADDR_WIDTH-1:0]  iInitialCodeAddress,
  output logic [ADDR_WIDTH-1:0]  oIP,
  output logic [ADDR_WIDTH-1:0]  oIP2,
  input  logic [INSTR_WIDTH-1:0] iInstruction1,
  input  logic [INSTR_WIDTH-1:0] iInstruction2,
  output logic [INSTR_WIDTH-1:0] oCurrentInstruction,
  output logic                   oInstructionAvailable,
  input  logic                   iEXEDone,
  input  logic                   iBranchTaken,
  output logic                   oMicroCodeReturnValue,
  output logic                   oExecutionDone,
  output logic                   oStackOverflow,
  output logic [DEPTH_WIDTH-1:0] oStackDepth
);

  fetchState_t            stateReg;
  logic [ADDR_WIDTH-1:0]  ipReg;
  logic [INSTR_WIDTH-1:0] instrReg;
  logic                   availReg;
  logic                   doneReg;
  logic                   overflowReg;

  logic [OP_LENGTH-1:0]  opcode;
  logic [ADDR_WIDTH-1:0] target;
  logic                  isReturn;
  logic                  isCall;
  logic                  exeAccept;
  logic                  triggerAccept;
  logic                  rasPush;
  logic                  rasPop;
  logic                  rasFull;
  logic                  rasEmpty;
  logic [ADDR_WIDTH-1:0] rasTop;

  assign opcode   = instrReg[INSTR_WIDTH-1 -: OP_LENGTH];
  assign target   = instrReg[TARGET_LSB +: ADDR_WIDTH];
  assign isReturn = (opcode == OPCODE_RETURN);
  assign isCall   = (opcode == OPCODE_CALL) && !isReturn;

  // The pulse cycle itself never completes an instruction: EXE needs at least two cycles.
  assign exeAccept     = (stateReg == ST_EXEC) && iEXEDone && !availReg;
  assign triggerAccept = (stateReg == ST_IDLE) && iTrigger && !doneReg;
  assign rasPush       = exeAccept && isCall && !rasFull;
  assign rasPop        = exeAccept && isReturn && !rasEmpty;

  return_address_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) ras (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (triggerAccept),
    .push    (rasPush),
    .pop     (rasPop),
    .pushAddr(ipReg),
    .topAddr (rasTop),
    .full    (rasFull),
    .empty   (rasEmpty),
    .depth   (oStackDepth)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stateReg    <= ST_IDLE;
      ipReg       <= '0;
      instrReg    <= '0;
      availReg    <= 1'b0;
      doneReg     <= 1'b0;
      overflowReg <= 1'b0;
    end else begin
      availReg <= 1'b0;
      doneReg  <= 1'b0;
      case (stateReg)
        ST_IDLE: begin
          if (triggerAccept) begin
            ipReg       <= iInitialCodeAddress;
            overflowReg <= 1'b0;
            stateReg    <= ST_FETCH;
          end
        end
        ST_FETCH: stateReg <= ST_LOAD;
        ST_LOAD: begin
          instrReg <= iInstruction1;
          ipReg    <= ipReg + 1'b1;
          availReg <= 1'b1;
          stateReg <= ST_EXEC;
        end
        ST_EXEC: begin
          if (exeAccept) begin
            if (isReturn) begin
              if (rasEmpty) begin
                doneReg  <= 1'b1;
                stateReg <= ST_IDLE;
              end else begin
                ipReg    <= rasTop;
                stateReg <= ST_FETCH;
              end
            end else if (isCall) begin
              if (rasFull) begin
                overflowReg <= 1'b1;
                doneReg     <= 1'b1;
                stateReg    <= ST_IDLE;
              end else begin
                // ipReg already holds call site + 1, which the stack captures this edge.
                ipReg    <= target;
                stateReg <= ST_FETCH;
              end
            end else if (iBranchTaken) begin
              instrReg <= iInstruction2;
              ipReg    <= target + 1'b1;
              availReg <= 1'b1;
            end else begin
              instrReg <= iInstruction1;
              ipReg    <= ipReg + 1'b1;
              availReg <= 1'b1;
            end
          end
        end
        default: stateReg <= ST_IDLE;
      endcase
    end
  end

  assign oIP                   = ipReg;
  assign oIP2                  = target;
  assign oCurrentInstruction   = instrReg;
  assign oInstructionAvailable = availReg;
  assign oMicroCodeReturnValue = instrReg[0];
  assign oExecutionDone        = doneReg;
  assign oStackOverflow        = overflowReg;

endmodule

// File: tb/tb_instruction_fetch_ras.sv
// Scoreboard bench for instruction_fetch_ras with a two-port synchronous IMEM model.
module tb_instruction_fetch_ras;
  import instruction_fetch_ras_pkg::*;

  localparam int AW = 16;
  localparam int IW = 64;
  localparam int RD = 2;
  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_RET  = DEFAULT_OPCODE_RETURN;
  localparam logic [7:0] OP_CALL = DEFAULT_OPCODE_CALL;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          iTrigger = 1'b0;
  logic          iEXEDone = 1'b0;
  logic          iBranchTaken = 1'b0;
  logic [AW-1:0] iInitialCodeAddress = '0;
  logic [AW-1:0] oIP, oIP2;
  logic [IW-1:0] iInstruction1 = '0;
  logic [IW-1:0] iInstruction2 = '0;
  logic [IW-1:0] oCurrentInstruction;
  logic          oInstructionAvailable, oMicroCodeReturnValue, oExecutionDone, oStackOverflow;
  logic [1:0]    oStackDepth;

  instruction_fetch_ras #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .RAS_DEPTH  (RD)
  ) dut (
    .Clock                (Clock),
    .Reset                (Reset),
    .iTrigger             (iTrigger),
    .iInitialCodeAddress  (iInitialCodeAddress),
    .oIP                  (oIP),
    .oIP2                 (oIP2),
    .iInstruction1        (iInstruction1),
    .iInstruction2        (iInstruction2),
    .oCurrentInstruction  (oCurrentInstruction),
    .oInstructionAvailable(oInstructionAvailable),
    .iEXEDone             (iEXEDone),
    .iBranchTaken         (iBranchTaken),
    .oMicroCodeReturnValue(oMicroCodeReturnValue),
    .oExecutionDone       (oExecutionDone),
    .oStackOverflow       (oStackOverflow),
    .oStackDepth          (oStackDepth)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        done;
    logic [63:0] instr;
    logic [15:0] ip;
    logic [1:0]  depth;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon;
  logic [63:0] prog [logic [15:0]];
  logic [63:0] mCur;
  logic [15:0] mIp;
  logic [15:0] mStack[$];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          cyc = 0;

  function automatic logic [63:0] mk(input logic [7:0] op, input logic [15:0] tgt, input logic [15:0] tag);
    return {op, 8'h00, tgt, 16'h0000, tag};
  endfunction

  function automatic logic [63:0] imem(input logic [15:0] a);
    if (prog.exists(a)) return prog[a];
    return mk(OP_NOP, 16'h0000, a);
  endfunction

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge Clock) begin
    iInstruction1 <= imem(oIP);
    iInstruction2 <= imem(oIP2);
    cyc <= cyc + 1;
  end

  // Every availability or done pulse must match the oldest pending expectation.
  always @(negedge Clock) begin
    if (oInstructionAvailable || oExecutionDone) begin
      $display("[TB] cyc=%0d %s ip=%h instr=%h depth=%0d ovf=%b", cyc,
               oExecutionDone ? "done " : "instr", oIP, oCurrentInstruction, oStackDepth, oStackOverflow);
      if (sb.size() == 0) begin
        checkValue("unexpected_pulse", 64'({oExecutionDone, oInstructionAvailable}), 64'd0);
      end else begin
        mon = sb.pop_front();
        checkValue("kind", 64'(oExecutionDone), 64'(mon.done));
        checkValue("latency", 64'(cyc), 64'(mon.due));
        checkValue("overflow", 64'(oStackOverflow), 64'(mon.ovf));
        if (!mon.done) begin
          checkValue("instr", oCurrentInstruction, mon.instr);
          checkValue("ip", 64'(oIP), 64'(mon.ip));
          checkValue("ip2", 64'(oIP2), 64'(mon.instr[47:32]));
          checkValue("ucode_ret", 64'(oMicroCodeReturnValue), 64'(mon.instr[0]));
          checkValue("depth", 64'(oStackDepth), 64'(mon.depth));
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    if (sb.size() != 0) begin
      checkValue("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic start(input logic [15:0] entry);
    exp_t e;
    @(negedge Clock);
    iTrigger = 1'b1;
    iInitialCodeAddress = entry;
    mStack.delete();
    mCur = imem(entry);
    mIp = entry + 16'd1;
    e.done = 1'b0; e.ovf = 1'b0; e.instr = mCur; e.ip = mIp; e.depth = 2'd0; e.due = cyc + 3;
    sb.push_back(e);
    @(negedge Clock);
    iTrigger = 1'b0;
  endtask

  task automatic step(input logic br);
    logic [7:0]  op;
    logic [15:0] tgt;
    exp_t        e;
    drain();
    @(negedge Clock);
    op = mCur[63:56];
    tgt = mCur[47:32];
    e.done = 1'b0; e.ovf = 1'b0; e.due = cyc + 1;
    if (op == OP_RET && mStack.size() == 0) begin
      e.done = 1'b1;
    end else if (op == OP_RET) begin
      mIp = mStack.pop_back();
      mCur = imem(mIp);
      mIp = mIp + 16'd1;
      e.due = cyc + 3;
    end else if (op == OP_CALL && mStack.size() == RD) begin
      e.done = 1'b1;
      e.ovf = 1'b1;
    end else if (op == OP_CALL) begin
      mStack.push_back(mIp);
      mCur = imem(tgt);
      mIp = tgt + 16'd1;
      e.due = cyc + 3;
    end else if (br) begin
      mCur = imem(tgt);
      mIp = tgt + 16'd1;
    end else begin
      mCur = imem(mIp);
      mIp = mIp + 16'd1;
    end
    e.instr = mCur; e.ip = mIp; e.depth = 2'(mStack.size());
    sb.push_back(e);
    iEXEDone = 1'b1;
    iBranchTaken = br;
    @(negedge Clock);
    iEXEDone = 1'b0;
    iBranchTaken = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    prog[16'h0013] = mk(OP_RET, 16'h0000, 16'h0013);
    prog[16'h0020] = mk(OP_NOP, 16'h0040, 16'h0020);
    prog[16'h0041] = mk(OP_RET, 16'h0000, 16'h0041);
    prog[16'h0030] = mk(OP_CALL, 16'h0100, 16'h0030);
    prog[16'h0100] = mk(OP_RET, 16'h0000, 16'h0100);
    prog[16'h0032] = mk(OP_RET, 16'h0000, 16'h0032);
    prog[16'h0050] = mk(OP_CALL, 16'h0060, 16'h0050);
    prog[16'h0060] = mk(OP_CALL, 16'h0070, 16'h0060);
    prog[16'h0070] = mk(OP_CALL, 16'h0080, 16'h0070);
    prog[16'h0090] = mk(OP_NOP, 16'hFFFF, 16'h0091);
    prog[16'h0001] = mk(OP_RET, 16'h0000, 16'h0001);

    repeat (3) @(negedge Clock);
    checkValue("rst_ip", 64'(oIP), 64'd0);
    checkValue("rst_instr", oCurrentInstruction, 64'd0);
    checkValue("rst_avail", 64'(oInstructionAvailable), 64'd0);
    checkValue("rst_done", 64'(oExecutionDone), 64'd0);
    checkValue("rst_ovf", 64'(oStackOverflow), 64'd0);
    checkValue("rst_depth", 64'(oStackDepth), 64'd0);
    Reset = 1'b1;

    // Sequential run; a trigger during the done pulse must be ignored.
    start(16'h0010);
    repeat (4) step(1'b0);
    iTrigger = 1'b1;
    iInitialCodeAddress = 16'h0055;
    @(negedge Clock);
    iTrigger = 1'b0;
    repeat (6) @(negedge Clock);
    checkValue("idle_ip", 64'(oIP), 64'h0014);

    // Zero-bubble taken branch; a lone iBranchTaken does nothing.
    start(16'h0020);
    drain();
    iBranchTaken = 1'b1;
    @(negedge Clock);
    iBranchTaken = 1'b0;
    step(1'b1);
    step(1'b0);
    step(1'b0);

    // CALL/RETURN with branch requests that must be ignored.
    start(16'h0030);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);

    // Overflow on the third nested CALL with a two-deep stack.
    start(16'h0050);
    repeat (3) step(1'b0);
    repeat (5) @(negedge Clock);
    checkValue("ovf_sticky", 64'(oStackOverflow), 64'd1);
    checkValue("ovf_depth", 64'(oStackDepth), 64'd2);
    start(16'h0013);
    step(1'b0);

    // Address wrap and trigger ignored during EXEC.
    start(16'h0090);
    step(1'b1);
    @(negedge Clock);
    iTrigger = 1'b1;
    iInitialCodeAddress = 16'h1234;
    @(negedge Clock);
    iTrigger = 1'b0;
    repeat (3) @(negedge Clock);
    checkValue("trig_ignored_ip", 64'(oIP), 64'h0000);
    checkValue("trig_ignored_instr", oCurrentInstruction, mCur);
    repeat (3) step(1'b0);

    // Asynchronous reset mid-EXEC, then a clean restart.
    start(16'h0010);
    step(1'b0);
    repeat (2) @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    checkValue("arst_ip", 64'(oIP), 64'd0);
    checkValue("arst_instr", oCurrentInstruction, 64'd0);
    checkValue("arst_avail", 64'(oInstructionAvailable), 64'd0);
    checkValue("arst_done", 64'(oExecutionDone), 64'd0);
    checkValue("arst_depth", 64'(oStackDepth), 64'd0);
    repeat (4) @(negedge Clock);
    Reset = 1'b1;
    start(16'h0013);
    step(1'b0);
    drain();
    repeat (4) @(negedge Clock);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
